audio_i2s_tx: RTL and testbench
===============================

# audio_i2s_tx

Serial audio transmitter that runs in the audio clock domain, directly downstream of the audio PLL's 11.2896 MHz output (256 × 44.1 kHz). It accepts signed 16-bit stereo sample pairs over a valid/ready handshake and drives a standard I2S link to the audio DAC:
- BCLK = clk/4 (64 × fs).
- LRCK = clk/256 (fs).
- SDATA is MSB-first with a one-BCLK delay after each LRCK edge.

A one-entry holding register decouples the sample producer from the frame timing. The block repeats the last frame on underrun.

## Interface
- `DATA_W`, default 16: sample width per channel. Must be ≤ 31.
- `clk`  in  1: audio clock, the PLL `outclk_0`, 11.2896 MHz.
- `rst`  in  1: asynchronous, active-high reset.
- `pll_locked`  in  1: PLL `locked`. Low acts as a synchronous hold/clear.
- `s_valid`  in  1: sample pair offered.
- `s_ready`  out  1: holding register empty. Reset value 0.
- `s_left`  in  DATA_W: left sample, two's complement.
- `s_right`  in  DATA_W: right sample, two's complement.
- `i2s_bclk`  out  1: bit clock. Reset value 0.
- `i2s_lrck`  out  1: word select, 0 = left, 1 = right. Reset value 0.
- `i2s_sdata`  out  1: serial data. Reset value 0.
- `underrun`  out  1: one-cycle pulse when a frame starts with no new sample. Reset value 0.

## Operation

**Frame counter `cnt[7:0]`**
- Increments every clk while `pll_locked` = 1. Wraps 255 → 0.
- `bclk` = `cnt[1]`.
- `lrck` = `cnt[7]`.
- Slot index `s` = `cnt[6:2]`, range 0..31 within each half-frame.

**Serial data**
- In slot `s`, `sdata` = bit `[DATA_W - s]` of the active channel word for `s` in 1..DATA_W, and 0 otherwise.
- The active channel word is left when `lrck` = 0, right when `lrck` = 1.
- Slot 0 carries the LSB-side zero; this is the I2S one-bit delay.

**Holding register**
- `hold_full` is set on `s_valid && s_ready`, which captures `s_left` and `s_right`.
- `s_ready` = `!hold_full && pll_locked`.

**Frame load** (the clk edge where `cnt` goes 255 → 0)
- If `hold_full`: the frame register takes the holding contents and `hold_full` clears.
- If not `hold_full`: the frame register keeps its previous pair (repeat) and `underrun` pulses for that one cycle.
- Simultaneous load and new handshake on the same edge: the frame register takes the old holding contents, and `hold` captures the new pair with `hold_full` staying 1.

**`pll_locked` low**
- `cnt` is forced to 0.
- All I2S outputs are forced to 0.
- `s_ready` = 0.
- `underrun` = 0.
- `hold_full` and the frame register are cleared, so the frame register reads 0 (silence).
- When lock returns, the first frame starts at `cnt` = 0 with LRCK low.

**Reset** (async `rst`)
- Clears `cnt`, `hold_full`, the frame register and all outputs, regardless of the frame phase at the time.

## Timing
- All outputs are registered. On each edge, the outputs are computed from the next value of `cnt`, so they change in the same edge where `cnt` changes. No combinational path from inputs to outputs.
- BCLK rises when `cnt[1:0]` goes 01 → 10. SDATA and LRCK change only on BCLK falling edges (`cnt[1:0]` goes 11 → 00), giving the DAC 2 clk of setup and 2 clk of hold.
- Sample-to-wire latency: a pair accepted at least one cycle before frame load appears starting 4 clk after load, with the left MSB in slot 1.
- Throughput: at most one pair per 256 clk. `s_ready` stays low from acceptance until the next frame load.

## Structure
- Shared package `audio_pkg`:
  - `FRAME_CLKS` = 256
  - `BCLK_DIV` = 4
  - `SLOTS_PER_CH` = 32
  - `sample_pair_t` struct `{left, right}`
- Sub-module `audio_frame_timer`: generates `cnt`, `bclk`, `lrck`, the slot index and a `frame_start` strobe; it owns the `pll_locked` gating. The top level holds the handshake, the holding/frame registers and the bit selection.

## Test plan
- **Reset and lock:** `rst` pulse, then `pll_locked` = 1. Expect:
  - All outputs 0 during reset.
  - BCLK period 4 clk, LRCK period 256 clk with 128 low first.
- **Known pattern:** send L = 0x8001, R = 0x7FFE before a frame start. Expect:
  - Left slots 1..16 carry 1000…0001.
  - Right slots 1..16 carry 0111…1110.
  - Slots 0 and 17..31 are 0.
- **Backpressure:** hold `s_valid` = 1 continuously. Expect exactly one acceptance per 256 clk, each occurring in the cycle after frame load.
- **Underrun:** send one pair (0x1234/0xABCD) then stop. Expect:
  - Next frame repeats 0x1234/0xABCD.
  - `underrun` is a 1-cycle pulse at that frame's load.
- **Simultaneous load and accept:** `hold_full` = 1 and `s_valid` asserted on the load edge. Expect the old pair transmitted, the new pair held, and no underrun.
- **Lock loss mid-frame:** drop `pll_locked` at `cnt` = 100. Expect:
  - Outputs 0 and `s_ready` = 0 on the next cycle.
  - On relock, `cnt` restarts at 0 and the frame is silent until a new pair is accepted.

Source files
------------

// File: rtl/audio_i2s_tx_pkg.sv
// audio_pkg: shared constants and types for the I2S transmitter slice.
//   FRAME_CLKS   clk cycles per stereo frame (one LRCK period)
//   BCLK_DIV     clk cycles per bit clock period
//   SLOTS_PER_CH bit slots in each half-frame
//   sample_pair_t left/right pair, stored at the widest supported width
package audio_pkg;

    localparam int FRAME_CLKS   = 256;
    localparam int BCLK_DIV     = 4;
    localparam int SLOTS_PER_CH = 32;

    localparam int CNT_W      = $clog2(FRAME_CLKS);
    localparam int BCLK_SH    = $clog2(BCLK_DIV);
    localparam int SLOT_W     = $clog2(SLOTS_PER_CH);
    localparam int MAX_DATA_W = 31;

    // Samples are zero-extended into the widest field; only the low DATA_W
    // bits are ever serialised.
    typedef struct packed {
        logic [MAX_DATA_W-1:0] left;
        logic [MAX_DATA_W-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: valid/ready sample-pair handshake.
//   master: producer (drives s_valid, s_left, s_right; sees s_ready)
//   slave : the transmitter (sees the pair; drives s_ready)
interface audio_i2s_tx_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_left;
    logic [DATA_W-1:0] s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);
endinterface

// File: rtl/audio_frame_timer.sv
// audio_frame_timer: free-running frame counter gated by PLL lock.
//   clk, rst         audio clock, async active-high reset
//   pll_locked_i     low forces the counter to 0 (synchronous hold/clear)
//   slot_next_o      slot index taken from the next counter value
//   lrck_next_o      channel select taken from the next counter value
//   frame_start_o    high in the cycle whose edge wraps the counter to 0
//   bclk_o, lrck_o   registered bit clock and word select
module audio_frame_timer
    import audio_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked_i,
    output logic [SLOT_W-1:0] slot_next_o,
    output logic              lrck_next_o,
    output logic              frame_start_o,
    output logic              bclk_o,
    output logic              lrck_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             bclk_q;
    logic             lrck_q;

    // Next counter value: count while locked, park at 0 otherwise.
    always_comb begin
        if (pll_locked_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    assign frame_start_o = pll_locked_i && (cnt_q == CNT_W'(FRAME_CLKS - 1));
    assign slot_next_o   = cnt_d[CNT_W-2:BCLK_SH];
    assign lrck_next_o   = cnt_d[CNT_W-1];

    // Counter and clock outputs; outputs follow the next count so they
    // move on the same edge as the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
            lrck_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= cnt_d[BCLK_SH-1];
            lrck_q <= cnt_d[CNT_W-1];
        end
    end

    assign bclk_o = bclk_q;
    assign lrck_o = lrck_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S transmitter with a one-entry holding register.
//   clk, rst     audio clock (256 x fs), async active-high reset
//   pll_locked   low clears all state and silences the link
//   s_if         slave side of the sample-pair handshake (DATA_W <= 31)
//   i2s_bclk     bit clock, clk/4
//   i2s_lrck     word select, clk/256, 0 = left
//   i2s_sdata    serial data, MSB first, one bit after each LRCK edge
//   underrun     one-cycle pulse when a frame starts with no new pair
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    audio_i2s_tx_if.slave     s_if,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_sdata,
    output logic              underrun
);

    logic [SLOT_W-1:0] slot_next_s;
    logic              lrck_next_s;
    logic              frame_start_s;
    logic              accept_s;

    sample_pair_t      hold_q,  hold_d;
    sample_pair_t      frame_q, frame_d;
    logic              hold_full_q, hold_full_d;
    logic              s_ready_q, s_ready_d;
    logic              sdata_q, sdata_d;
    logic              underrun_q, underrun_d;
    logic [MAX_DATA_W-1:0] word_s;
    logic [SLOT_W-1:0]     bit_idx_s;

    audio_frame_timer u_timer (
        .clk           (clk),
        .rst           (rst),
        .pll_locked_i  (pll_locked),
        .slot_next_o   (slot_next_s),
        .lrck_next_o   (lrck_next_s),
        .frame_start_o (frame_start_s),
        .bclk_o        (i2s_bclk),
        .lrck_o        (i2s_lrck)
    );

    assign accept_s = s_if.s_valid && s_ready_q;

    // Holding/frame register update. Load happens before capture so a
    // same-edge handshake refills the holding register after it empties.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        frame_d     = frame_q;
        underrun_d  = 1'b0;
        if (!pll_locked) begin
            hold_d      = '0;
            hold_full_d = 1'b0;
            frame_d     = '0;
        end else begin
            if (frame_start_s) begin
                if (hold_full_q) begin
                    frame_d     = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    underrun_d  = 1'b1;
                end
            end else begin
                frame_d = frame_q;
            end
            if (accept_s) begin
                hold_d.left  = MAX_DATA_W'(s_if.s_left);
                hold_d.right = MAX_DATA_W'(s_if.s_right);
                hold_full_d  = 1'b1;
            end else begin
                hold_d = hold_q;
            end
        end
    end

    // Ready for the next cycle depends on the next fill state, so the
    // handshake never sees a full register as ready.
    assign s_ready_d = pll_locked && !hold_full_d;

    // Bit selection from the next slot: slot s carries bit DATA_W-s, slot 0
    // and the slots past the LSB carry zero.
    always_comb begin
        word_s    = lrck_next_s ? frame_d.right : frame_d.left;
        bit_idx_s = SLOT_W'(DATA_W) - slot_next_s;
        if ((slot_next_s >= SLOT_W'(1)) && (slot_next_s <= SLOT_W'(DATA_W))) begin
            sdata_d = word_s[bit_idx_s];
        end else begin
            sdata_d = 1'b0;
        end
    end

    // Handshake, data and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            frame_q     <= '0;
            hold_full_q <= 1'b0;
            s_ready_q   <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            frame_q     <= frame_d;
            hold_full_q <= hold_full_d;
            s_ready_q   <= s_ready_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
        end
    end

    assign s_if.s_ready = s_ready_q;
    assign i2s_sdata    = sdata_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

    logic clk;
    logic rst;
    logic pll_locked;
    logic i2s_bclk, i2s_lrck, i2s_sdata, underrun;

    audio_i2s_tx_if #(.DATA_W(16)) bus();

    audio_i2s_tx #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .s_if       (bus),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrck   (i2s_lrck),
        .i2s_sdata  (i2s_sdata),
        .underrun   (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    // Reference model state, written from the frame rules.
    int          m_cnt = 0;
    bit          m_full = 0, m_ready = 0, m_under = 0, m_acc = 0;
    logic [15:0] m_hl = '0, m_hr = '0, m_fl = '0, m_fr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
        return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every output against it.
    task automatic tick();
        bit load;
        int s;
        logic [15:0] w;
        logic e_sd;
        @(posedge clk);
        m_acc = 0;
        if (rst || !pll_locked) begin
            m_cnt = 0; m_full = 0; m_ready = 0; m_under = 0;
            m_hl = '0; m_hr = '0; m_fl = '0; m_fr = '0;
        end else begin
            load    = (m_cnt == 255);
            m_acc   = bus.s_valid && m_ready;
            m_under = load && !m_full;
            if (load && m_full) begin
                m_fl = m_hl; m_fr = m_hr;
            end
            if (m_acc) begin
                m_hl = bus.s_left; m_hr = bus.s_right; m_full = 1;
            end else if (load) begin
                m_full = 0;
            end
            m_cnt   = (m_cnt + 1) % 256;
            m_ready = !m_full;
        end
        #1;
        s = (m_cnt / 4) % 32;
        w = (m_cnt >= 128) ? m_fr : m_fl;
        e_sd = (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
        chk("bclk",     i2s_bclk,    (m_cnt / 2) % 2);
        chk("lrck",     i2s_lrck,    m_cnt / 128);
        chk("sdata",    i2s_sdata,   e_sd);
        chk("s_ready",  bus.s_ready, m_ready);
        chk("underrun", underrun,    m_under);
    endtask

    task automatic offer(input logic [15:0] l, input logic [15:0] r);
        bit got = 0;
        bus.s_valid = 1'b1; bus.s_left = l; bus.s_right = r;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (m_acc) begin got = 1; break; end
        end
        bus.s_valid = 1'b0;
        chk("offer_accepted", got, 1);
    endtask

    task automatic wait_load();
        bit seen = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (m_cnt == 0) begin seen = 1; break; end
        end
        chk("load_seen", seen, 1);
    endtask

    // Sample SDATA on each BCLK-high cycle across 256 clocks into slot order.
    task automatic collect(output logic [63:0] v);
        v = '0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (m_cnt % 4 == 2) v[63 - (m_cnt / 4)] = i2s_sdata;
        end
    endtask

    initial begin
        logic [63:0] v;
        logic [15:0] a_l, a_r, b_l, b_r;
        bit prev, rose;
        int n, low, acc;

        rst = 1'b1; pll_locked = 1'b0;
        bus.s_valid = 1'b0; bus.s_left = '0; bus.s_right = '0;
        repeat (4) tick();
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_ready", bus.s_ready, 0);
        rst = 1'b0; pll_locked = 1'b1;

        // LRCK period and duty.
        prev = i2s_lrck; rose = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (!prev && i2s_lrck) begin rose = 1; break; end
            prev = i2s_lrck;
        end
        chk("lrck_first_rise", rose, 1);
        n = 0; low = 0; prev = i2s_lrck;
        for (int k = 0; k < 600; k++) begin
            tick(); n++;
            if (!i2s_lrck) low++;
            if (!prev && i2s_lrck) break;
            prev = i2s_lrck;
        end
        chk("lrck_period", n, 256);
        chk("lrck_low", low, 128);

        // Known pattern.
        offer(16'h8001, 16'h7FFE);
        wait_load();
        collect(v);
        chk("pattern_frame", v, frame_bits(16'h8001, 16'h7FFE));
        chk("pattern_then_underrun", underrun, 1);

        // Underrun repeats last frame.
        offer(16'h1234, 16'hABCD);
        wait_load();
        chk("ur_fresh_load", underrun, 0);
        collect(v);
        chk("ur_first_frame", v, frame_bits(16'h1234, 16'hABCD));
        chk("ur_pulse", underrun, 1);
        tick();
        chk("ur_pulse_width", underrun, 0);
        collect(v);
        chk("ur_repeat_frame", v, frame_bits(16'h1234, 16'hABCD));

        // Backpressure: valid held high, one acceptance per frame, right after load.
        wait_load();
        acc = 0;
        bus.s_valid = 1'b1;
        bus.s_left = 16'($urandom); bus.s_right = 16'($urandom);
        for (int k = 0; k < 1024; k++) begin
            if (bus.s_ready && bus.s_valid) begin
                acc++;
                chk("bp_phase", m_cnt, 0);
                tick();
                bus.s_left = 16'($urandom); bus.s_right = 16'($urandom);
            end else begin
                tick();
            end
        end
        bus.s_valid = 1'b0;
        chk("bp_count", acc, 4);

        // Holding full with a new pair pending across the load edge.
        a_l = 16'($urandom); a_r = 16'($urandom);
        b_l = 16'($urandom); b_r = 16'($urandom);
        offer(a_l, a_r);
        bus.s_valid = 1'b1; bus.s_left = b_l; bus.s_right = b_r;
        wait_load();
        chk("sim_no_underrun", underrun, 0);
        rose = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (m_acc) begin rose = 1; break; end
        end
        bus.s_valid = 1'b0;
        chk("sim_b_accepted", rose, 1);
        wait_load();
        chk("sim_b_loaded", underrun, 0);
        collect(v);
        chk("sim_b_frame", v, frame_bits(b_l, b_r));

        // Lock loss mid-frame.
        offer(16'h5A5A, 16'hA5A5);
        rose = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (m_cnt == 100) begin rose = 1; break; end
        end
        chk("lol_reach_100", rose, 1);
        pll_locked = 1'b0;
        tick();
        chk("lol_bclk", i2s_bclk, 0);
        chk("lol_lrck", i2s_lrck, 0);
        chk("lol_sdata", i2s_sdata, 0);
        chk("lol_ready", bus.s_ready, 0);
        repeat (5) tick();
        pll_locked = 1'b1;
        tick();
        chk("relock_ready", bus.s_ready, 1);
        wait_load();
        collect(v);
        chk("relock_silent", v, 64'd0);

        // Randomised traffic with occasional lock drops.
        for (int k = 0; k < 3000; k++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_left  = 16'($urandom);
            bus.s_right = 16'($urandom);
            pll_locked  = ($urandom_range(0, 799) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
